// File: rtl/pipe_ctl_chain.sv
// Control-signal pipeline for a five-stage MIPS-style core: carries decoded ID
// controls through EXE, MEM and WB, and inserts bubbles for load-use stalls and post-jump slots.
module pipe_ctl_chain (
    input  logic        clock,
    input  logic        reset,
    input  logic        wreg,
    input  logic        m2reg,
    input  logic        wmem,
    input  logic        jal,
    input  logic        aluimm,
    input  logic        shift,
    input  logic [3:0]  aluc,
    input  logic [4:0]  rn,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    output logic        ewreg,
    output logic        em2reg,
    output logic        ewmem,
    output logic        ejal,
    output logic        ealuimm,
    output logic        eshift,
    output logic [3:0]  ealuc,
    output logic [4:0]  ern,
    output logic        mwreg,
    output logic        mm2reg,
    output logic        mwmem,
    output logic [4:0]  mrn,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [4:0]  wrn,
    output logic        ebubble,
    output logic [31:0] retire_cnt,
    output logic [31:0] stall_cnt
);

    logic id_ok;
    logic evalid;
    logic mvalid;
    logic wvalid;

    // A stalled or cancelled ID instruction enters EXE as a bubble.
    assign id_ok = wpcir & ~ebubble;

    // NOTE: all state uses non-blocking assignments so every stage samples the
    // previous stage's pre-edge value; blocking here would collapse the pipeline.
    always_ff @(posedge clock) begin
        // NOTE: reset is synchronous and clears every register, including the
        // valid bits, so in-flight instructions can never reach the retire counter.
        if (reset) begin
            ewreg      <= 1'b0;
            em2reg     <= 1'b0;
            ewmem      <= 1'b0;
            ejal       <= 1'b0;
            ealuimm    <= 1'b0;
            eshift     <= 1'b0;
            ealuc      <= 4'd0;
            ern        <= 5'd0;
            mwreg      <= 1'b0;
            mm2reg     <= 1'b0;
            mwmem      <= 1'b0;
            mrn        <= 5'd0;
            wwreg      <= 1'b0;
            wm2reg     <= 1'b0;
            wrn        <= 5'd0;
            ebubble    <= 1'b0;
            evalid     <= 1'b0;
            mvalid     <= 1'b0;
            wvalid     <= 1'b0;
            retire_cnt <= 32'd0;
            stall_cnt  <= 32'd0;
        end else begin
            if (id_ok) begin
                ewreg   <= wreg;
                em2reg  <= m2reg;
                ewmem   <= wmem;
                ejal    <= jal;
                ealuimm <= aluimm;
                eshift  <= shift;
                ealuc   <= aluc;
                ern     <= jal ? 5'd31 : rn;
            end else begin
                ewreg   <= 1'b0;
                em2reg  <= 1'b0;
                ewmem   <= 1'b0;
                ejal    <= 1'b0;
                ealuimm <= 1'b0;
                eshift  <= 1'b0;
                ealuc   <= 4'd0;
                ern     <= 5'd0;
            end

            mwreg  <= ewreg;
            mm2reg <= em2reg;
            mwmem  <= ewmem;
            mrn    <= ern;

            wwreg  <= mwreg;
            wm2reg <= mm2reg;
            wrn    <= mrn;

            evalid <= id_ok;
            mvalid <= evalid;
            wvalid <= mvalid;

            // Gating with id_ok means a stalled jump re-evaluates later and a
            // cancelled slot cannot redirect.
            ebubble <= (pcsource != 2'b00) & id_ok;

            if (wvalid)
                retire_cnt <= retire_cnt + 32'd1;
            if (!wpcir)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctl_chain.sv
// Directed bench for pipe_ctl_chain: hand-computed expectations for forwarding
// latency, stall bubbles, jump cancellation, mid-stream reset and counter wrap.
module tb_pipe_ctl_chain;

    logic        clock;
    logic        reset;
    logic        wreg, m2reg, wmem, jal, aluimm, shift;
    logic [3:0]  aluc;
    logic [4:0]  rn;
    logic        wpcir;
    logic [1:0]  pcsource;
    logic        ewreg, em2reg, ewmem, ejal, ealuimm, eshift;
    logic [3:0]  ealuc;
    logic [4:0]  ern;
    logic        mwreg, mm2reg, mwmem;
    logic [4:0]  mrn;
    logic        wwreg, wm2reg;
    logic [4:0]  wrn;
    logic        ebubble;
    logic [31:0] retire_cnt;
    logic [31:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_ctl_chain dut (
        .clock      (clock),
        .reset      (reset),
        .wreg       (wreg),
        .m2reg      (m2reg),
        .wmem       (wmem),
        .jal        (jal),
        .aluimm     (aluimm),
        .shift      (shift),
        .aluc       (aluc),
        .rn         (rn),
        .wpcir      (wpcir),
        .pcsource   (pcsource),
        .ewreg      (ewreg),
        .em2reg     (em2reg),
        .ewmem      (ewmem),
        .ejal       (ejal),
        .ealuimm    (ealuimm),
        .eshift     (eshift),
        .ealuc      (ealuc),
        .ern        (ern),
        .mwreg      (mwreg),
        .mm2reg     (mm2reg),
        .mwmem      (mwmem),
        .mrn        (mrn),
        .wwreg      (wwreg),
        .wm2reg     (wm2reg),
        .wrn        (wrn),
        .ebubble    (ebubble),
        .retire_cnt (retire_cnt),
        .stall_cnt  (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic w, input logic m2, input logic wm, input logic j,
                         input logic ai, input logic sh, input logic [3:0] c,
                         input logic [4:0] r, input logic ok, input logic [1:0] ps);
        wreg = w; m2reg = m2; wmem = wm; jal = j; aluimm = ai; shift = sh;
        aluc = c; rn = r; wpcir = ok; pcsource = ps;
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 4'd0, 5'd0, 1'b1, 2'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nop();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        nop();
        step();
        step();
        check("rst_ewreg",   {31'd0, ewreg},   32'd0);
        check("rst_ern",     {27'd0, ern},     32'd0);
        check("rst_mrn",     {27'd0, mrn},     32'd0);
        check("rst_wrn",     {27'd0, wrn},     32'd0);
        check("rst_ebubble", {31'd0, ebubble}, 32'd0);
        check("rst_retire",  retire_cnt,       32'd0);
        check("rst_stall",   stall_cnt,        32'd0);
        reset = 1'b0;

        // add r8: one edge to EXE, two to MEM, three to WB, counted on the fourth
        issue(1, 0, 0, 0, 0, 0, 4'b0000, 5'd8, 1'b1, 2'd0);
        step();
        check("add_ewreg", {31'd0, ewreg}, 32'd1);
        check("add_ern",   {27'd0, ern},   32'd8);
        nop();
        step();
        check("add_mwreg", {31'd0, mwreg}, 32'd1);
        check("add_mrn",   {27'd0, mrn},   32'd8);
        check("nop_ewreg", {31'd0, ewreg}, 32'd0);
        step();
        check("add_wwreg",     {31'd0, wwreg}, 32'd1);
        check("add_wrn",       {27'd0, wrn},   32'd8);
        check("add_retire_e3", retire_cnt,     32'd0);
        step();
        check("add_retire_e4", retire_cnt,     32'd1);

        // lw r9 followed by one load-use stall cycle
        do_reset();
        issue(1, 1, 0, 0, 0, 0, 4'b0000, 5'd9, 1'b1, 2'd0);
        step();
        check("lw_em2reg", {31'd0, em2reg}, 32'd1);
        check("lw_ern",    {27'd0, ern},    32'd9);
        check("lw_stall0", stall_cnt,       32'd0);
        issue(1, 0, 0, 0, 0, 0, 4'b0000, 5'd10, 1'b0, 2'd0);
        step();
        check("stl_ewreg",  {31'd0, ewreg},  32'd0);
        check("stl_em2reg", {31'd0, em2reg}, 32'd0);
        check("stl_ern",    {27'd0, ern},    32'd0);
        check("stl_mm2reg", {31'd0, mm2reg}, 32'd1);
        check("stl_mrn",    {27'd0, mrn},    32'd9);
        check("stl_cnt",    stall_cnt,       32'd1);
        nop();
        step();
        check("stl_cnt_hold", stall_cnt, 32'd1);
        step();
        check("stl_retire_lw", retire_cnt, 32'd1);
        step();
        check("stl_retire_bubble", retire_cnt, 32'd1);
        step();
        check("stl_retire_nop", retire_cnt, 32'd2);

        // jal: ern forced to 31, next slot cancelled even if it wants to branch
        do_reset();
        issue(1, 0, 0, 1, 0, 0, 4'b0000, 5'd0, 1'b1, 2'b11);
        step();
        check("jal_ern",     {27'd0, ern},     32'd31);
        check("jal_ejal",    {31'd0, ejal},    32'd1);
        check("jal_ewreg",   {31'd0, ewreg},   32'd1);
        check("jal_ebubble", {31'd0, ebubble}, 32'd1);
        issue(1, 0, 0, 0, 0, 0, 4'b0000, 5'd5, 1'b1, 2'b01);
        step();
        check("slot_ewreg",   {31'd0, ewreg},   32'd0);
        check("slot_ern",     {27'd0, ern},     32'd0);
        check("slot_ejal",    {31'd0, ejal},    32'd0);
        check("slot_ebubble", {31'd0, ebubble}, 32'd0);
        check("slot_mrn",     {27'd0, mrn},     32'd31);
        check("slot_stall",   stall_cnt,        32'd0);

        // beq taken while stalled: jump waits for the stall to clear
        do_reset();
        issue(0, 0, 0, 0, 0, 0, 4'b0010, 5'd0, 1'b0, 2'b01);
        step();
        check("beq_stl_ebubble", {31'd0, ebubble}, 32'd0);
        check("beq_stl_cnt",     stall_cnt,        32'd1);
        check("beq_stl_ealuc",   {28'd0, ealuc},   32'd0);
        issue(0, 0, 0, 0, 0, 0, 4'b0010, 5'd0, 1'b1, 2'b01);
        step();
        check("beq_go_ebubble", {31'd0, ebubble}, 32'd1);
        check("beq_go_ealuc",   {28'd0, ealuc},   32'd2);
        issue(0, 0, 1, 0, 1, 1, 4'b1010, 5'd17, 1'b1, 2'd0);
        step();
        check("beq_slot_ebubble", {31'd0, ebubble}, 32'd0);
        check("beq_slot_ealuc",   {28'd0, ealuc},   32'd0);
        check("beq_slot_ewmem",   {31'd0, ewmem},   32'd0);
        step();
        check("sw_ewmem",   {31'd0, ewmem},   32'd1);
        check("sw_ealuimm", {31'd0, ealuimm}, 32'd1);
        check("sw_eshift",  {31'd0, eshift},  32'd1);
        check("sw_ealuc",   {28'd0, ealuc},   32'd10);
        check("sw_ern",     {27'd0, ern},     32'd17);
        nop();
        step();
        check("sw_mwmem", {31'd0, mwmem}, 32'd1);
        check("sw_mrn",   {27'd0, mrn},   32'd17);

        // three instructions in flight, then reset discards them
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            issue(1, 0, 0, 0, 0, 0, 4'b0000, 5'(i), 1'b1, 2'd0);
            step();
        end
        check("fly_ern",   {27'd0, ern},   32'd3);
        check("fly_mrn",   {27'd0, mrn},   32'd2);
        check("fly_wrn",   {27'd0, wrn},   32'd1);
        check("fly_wwreg", {31'd0, wwreg}, 32'd1);
        reset = 1'b1;
        issue(0, 0, 0, 0, 0, 0, 4'd0, 5'd0, 1'b0, 2'd0);
        step();
        reset = 1'b0;
        check("mid_ewreg",  {31'd0, ewreg}, 32'd0);
        check("mid_mwreg",  {31'd0, mwreg}, 32'd0);
        check("mid_wwreg",  {31'd0, wwreg}, 32'd0);
        check("mid_ern",    {27'd0, ern},   32'd0);
        check("mid_mrn",    {27'd0, mrn},   32'd0);
        check("mid_wrn",    {27'd0, wrn},   32'd0);
        check("mid_retire", retire_cnt,     32'd0);
        check("mid_stall",  stall_cnt,      32'd0);
        step();
        step();
        step();
        check("post_retire", retire_cnt, 32'd0);
        check("post_stall",  stall_cnt,  32'd3);

        // retire counter wrap from a forced all-ones value
        do_reset();
        nop();
        step();
        step();
        step();
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        #1;
        check("wrap_pre", retire_cnt, 32'hFFFF_FFFF);
        step();
        check("wrap_zero", retire_cnt, 32'd0);
        step();
        check("wrap_one", retire_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
